// File: rtl/imem_pkg.sv
// Shared constants and helpers for the fetch-stage instruction memory.
// Fault encodings, the NOP returned on faulting fetches, and the byte-lane count.
package imem_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [31:0] word_t;

    // Misalignment outranks out-of-range when both apply.
    function automatic logic [1:0] fault_decode(input logic misalign, input logic out_of_range);
        logic [1:0] fault;
        fault = FAULT_NONE;
        if (misalign) begin
            fault = FAULT_MISALIGN;
        end else if (out_of_range) begin
            fault = FAULT_RANGE;
        end
        return fault;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-organised program store: one byte-lane-masked write port and one registered read port.
// The array itself is never reset; only the read data register is.
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic [NUM_LANES-1:0]           wbe,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    word_t mem_q [DEPTH_WORDS];
    word_t rdata_d, rdata_q;

    for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
        always_ff @(posedge clk) begin
            if (we && wbe[lane]) begin
                mem_q[waddr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (reset) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Handshaked instruction memory for the fetch stage: one instruction per accepted PC, one cycle
// of latency, with a run-time loader port, redirect flush and misaligned/out-of-range flagging.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [31:0]          load_data,
    input  logic [NUM_LANES-1:0] load_be,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_pc,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_instr,
    output logic [ADDR_W-1:0]    rsp_pc,
    output logic [1:0]           rsp_fault
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two and at least 2");
    end
    if (ADDR_W <= IDX_W + 2) begin : g_bad_addr_w
        $error("ADDR_W too narrow for DEPTH_WORDS");
    end

    // Fetch decode
    logic             pc_misalign;
    logic             pc_out_of_range;
    logic [1:0]       req_fault;
    logic [IDX_W-1:0] req_idx;
    logic             req_accept;

    assign pc_misalign     = |req_pc[1:0];
    assign pc_out_of_range = |req_pc[ADDR_W-1:IDX_W+2];
    assign req_fault       = fault_decode(pc_misalign, pc_out_of_range);
    assign req_idx         = req_pc[IDX_W+1:2];

    // Loader decode; the byte offset of a load address carries no meaning.
    logic             load_out_of_range;
    logic [IDX_W-1:0] load_idx;
    logic             unused_load_lsb;

    assign load_out_of_range = |load_addr[ADDR_W-1:IDX_W+2];
    assign load_idx          = load_addr[IDX_W+1:2];
    assign unused_load_lsb   = ^load_addr[1:0];

    // Output register
    logic              rsp_valid_d, rsp_valid_q;
    logic [ADDR_W-1:0] rsp_pc_d, rsp_pc_q;
    logic [1:0]        rsp_fault_d, rsp_fault_q;

    assign req_ready  = !reset && !flush && !load_en && (!rsp_valid_q || rsp_ready);
    assign req_accept = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        if (reset) begin
            rsp_valid_d = 1'b0;
            rsp_pc_d    = '0;
            rsp_fault_d = FAULT_NONE;
        end else if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_pc_d    = req_pc;
            rsp_fault_d = req_fault;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rsp_valid_q <= rsp_valid_d;
        rsp_pc_q    <= rsp_pc_d;
        rsp_fault_q <= rsp_fault_d;
    end

    // Store; the read register only advances on a non-faulting accept, so it holds under stall.
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    assign ram_we = load_en && !load_out_of_range && !reset;
    assign ram_re = req_accept && (req_fault == FAULT_NONE);

    imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (ram_we),
        .waddr(load_idx),
        .wdata(load_data),
        .wbe  (load_be),
        .re   (ram_re),
        .raddr(req_idx),
        .rdata(ram_rdata)
    );

    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_pc    = rsp_pc_q;
        rsp_fault = rsp_fault_q;
        rsp_instr = (rsp_fault_q != FAULT_NONE) ? NOP_INSTR : ram_rdata;
    end

    stall_holds_response: assert property (
        @(posedge clk) disable iff (reset)
        (rsp_valid_q && !rsp_ready && !flush)
            |=> (rsp_valid_q && $stable(rsp_pc_q) && $stable(rsp_fault_q) && $stable(rsp_instr))
    );

    no_load_fetch_overlap: assert property (
        @(posedge clk) disable iff (reset) !(ram_we && ram_re)
    );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: a table of back-to-back fetches plus hand-written
// sequences for back-pressure, flush, load priority and mid-stream reset.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [3:0]  load_be;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;

    int total = 0;
    int bad   = 0;

    instr_fetch_mem #(
        .DEPTH_WORDS(64),
        .ADDR_W     (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_be  (load_be),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_pc   (req_pc),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_pc   (rsp_pc),
        .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        load_be   = be;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"fetch_0x0",   32'h0000_0000, 32'h0094_0333, 2'b00};
        vecs[1] = '{"fetch_0x4",   32'h0000_0004, 32'h4139_03B3, 2'b00};
        vecs[2] = '{"fetch_0x8",   32'h0000_0008, 32'hFF5A_FFB3, 2'b00};
        vecs[3] = '{"fetch_0x2",   32'h0000_0002, 32'h0000_0013, 2'b01};
        vecs[4] = '{"fetch_0x100", 32'h0000_0100, 32'h0000_0013, 2'b10};
        vecs[5] = '{"fetch_0x102", 32'h0000_0102, 32'h0000_0013, 2'b01};
        vecs[6] = '{"fetch_0x4b",  32'h0000_0004, 32'h4139_03B3, 2'b00};

        reset     = 1'b1;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        load_be   = '0;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b1;

        tick();
        tick();
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'h0);
        check("reset_rsp_pc", rsp_pc, 32'h0);
        check("reset_rsp_fault", {30'b0, rsp_fault}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);

        do_load(32'h0, 32'h0094_0333, 4'hF);
        do_load(32'h4, 32'h4139_03B3, 4'hF);
        do_load(32'h8, 32'hFFFF_FFFF, 4'hF);
        do_load(32'h8, 32'h035A_02B3, 4'b0101);
        // Out of range: would alias word 0 if not dropped.
        do_load(32'h100, 32'hDEAD_BEEF, 4'hF);

        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1;
            req_pc    = vecs[i].pc;
            #1;
            check({vecs[i].name, "_req_ready"}, {31'b0, req_ready}, 32'd1);
            tick();
            check({vecs[i].name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({vecs[i].name, "_instr"}, rsp_instr, vecs[i].instr);
            check({vecs[i].name, "_pc"}, rsp_pc, vecs[i].pc);
            check({vecs[i].name, "_fault"}, {30'b0, rsp_fault}, {30'b0, vecs[i].fault});
        end
        req_valid = 1'b0;
        tick();
        check("drain_valid", {31'b0, rsp_valid}, 32'd0);

        // Back-pressure for three cycles, then release with no bubble.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        tick();
        check("bp_first_instr", rsp_instr, 32'h0094_0333);
        req_pc = 32'h4;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_req_ready_%0d", c), {31'b0, req_ready}, 32'd0);
            tick();
            check($sformatf("bp_valid_%0d", c), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("bp_instr_%0d", c), rsp_instr, 32'h0094_0333);
            check($sformatf("bp_pc_%0d", c), rsp_pc, 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
        check("bp_next_instr", rsp_instr, 32'h4139_03B3);
        check("bp_next_pc", rsp_pc, 32'h4);

        // Hold a response, overwrite its source word, then flush it.
        req_pc = 32'h8;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("hold_instr", rsp_instr, 32'hFF5A_FFB3);
        do_load(32'h8, 32'h0000_0000, 4'hF);
        check("load_keeps_valid", {31'b0, rsp_valid}, 32'd1);
        check("load_keeps_instr", rsp_instr, 32'hFF5A_FFB3);
        check("load_keeps_pc", rsp_pc, 32'h8);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        #1;
        check("flush_req_ready", {31'b0, req_ready}, 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        check("flush_not_accepted", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h8;
        tick();
        req_valid = 1'b0;
        check("overwrite_visible", rsp_instr, 32'h0);

        // Load and fetch requested together: load wins, fetch follows.
        load_en   = 1'b1;
        load_addr = 32'hC;
        load_data = 32'h1234_5678;
        load_be   = 4'hF;
        req_valid = 1'b1;
        req_pc    = 32'hC;
        #1;
        check("load_blocks_ready", {31'b0, req_ready}, 32'd0);
        tick();
        load_en = 1'b0;
        check("load_cycle_no_rsp", {31'b0, rsp_valid}, 32'd0);
        #1;
        check("after_load_ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("after_load_instr", rsp_instr, 32'h1234_5678);
        check("after_load_pc", rsp_pc, 32'hC);

        // Reset while a response is held; store contents must survive.
        req_pc = 32'h4;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("pre_reset_instr", rsp_instr, 32'h4139_03B3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_valid", {31'b0, rsp_valid}, 32'd0);
        check("midreset_instr", rsp_instr, 32'h0);
        check("midreset_pc", rsp_pc, 32'h0);
        check("midreset_fault", {30'b0, rsp_fault}, 32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        tick();
        req_valid = 1'b0;
        check("refetch_valid", {31'b0, rsp_valid}, 32'd1);
        check("refetch_instr", rsp_instr, 32'h0094_0333);
        check("refetch_fault", {30'b0, rsp_fault}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
